// File: rtl/pc_redirect_pkg.sv
// Shared types and widths for the PC redirect controller.
// Used by pc_redirect_ctrl and its optional statistics counter.
package pc_redirect_pkg;

    localparam int unsigned PC_W   = 32;
    localparam int unsigned HALF_W = 16;

    typedef enum logic [2:0] {
        StIdle,
        StRetHi,
        StRetLo,
        StRetLd,
        StIntPushHi,
        StIntPushLo,
        StIntLd
    } state_e;

endpackage

// File: rtl/redirect_stat_cnt.sv
// Free-running count of PC redirects (cycles with pc_load high), wrapping at 16 bits.
// Only instantiated when REDIRECT_STAT_EN is defined.
module redirect_stat_cnt
    import pc_redirect_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    output logic [HALF_W-1:0] cnt
);

    logic [HALF_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (inc) begin
            cnt_q <= cnt_q + HALF_W'(1);
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Program-flow redirect sequencer: jumps, RET (two-half PC pop) and interrupts (EPC push).
// Optional redirect counter output enabled by defining REDIRECT_STAT_EN.
module pc_redirect_ctrl
    import pc_redirect_pkg::*;
#(
    parameter logic [PC_W-1:0] INT_VECTOR = 32'h0000_0020
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              jmp_taken,
    input  logic [PC_W-1:0]   jmp_target,
    input  logic              ret_req,
    input  logic              intr,
    input  logic [PC_W-1:0]   ret_pc,
    input  logic [HALF_W-1:0] mem_rdata,
    output logic              pc_load,
    output logic [PC_W-1:0]   pc_next,
    output logic              freeze_pc,
    output logic              flush_fd,
    output logic              flush_de,
    output logic              mem_req,
    output logic              mem_we,
    output logic [HALF_W-1:0] mem_wdata,
    output logic              sp_inc,
    output logic              sp_dec,
`ifdef REDIRECT_STAT_EN
    output logic [HALF_W-1:0] redirect_cnt,
`endif
    output logic              busy
);

    state_e            state_q, state_d;
    logic              int_pend_q, int_pend_d;
    logic [PC_W-1:0]   epc_q, epc_d;
    logic [HALF_W-1:0] hi_q, hi_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            int_pend_q <= 1'b0;
            epc_q      <= '0;
            hi_q       <= '0;
        end else begin
            state_q    <= state_d;
            int_pend_q <= int_pend_d;
            epc_q      <= epc_d;
            hi_q       <= hi_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        int_pend_d = int_pend_q | intr;
        epc_d      = epc_q;
        hi_d       = hi_q;
        pc_load    = 1'b0;
        pc_next    = '0;
        flush_fd   = 1'b0;
        flush_de   = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_wdata  = '0;
        sp_inc     = 1'b0;
        sp_dec     = 1'b0;

        unique case (state_q)
            StIdle: begin
                // A same-cycle intr pulse counts as pending so service starts immediately.
                if (!stall) begin
                    if (jmp_taken) begin
                        pc_load  = 1'b1;
                        pc_next  = jmp_target;
                        flush_fd = 1'b1;
                        flush_de = 1'b1;
                    end else if (ret_req) begin
                        state_d = StRetHi;
                    end else if (int_pend_q || intr) begin
                        epc_d      = ret_pc;
                        int_pend_d = 1'b0;
                        state_d    = StIntPushHi;
                    end
                end
            end
            StRetHi: begin
                mem_req = 1'b1;
                sp_inc  = 1'b1;
                state_d = StRetLo;
            end
            StRetLo: begin
                hi_d    = mem_rdata;
                mem_req = 1'b1;
                sp_inc  = 1'b1;
                state_d = StRetLd;
            end
            StRetLd: begin
                pc_load  = 1'b1;
                pc_next  = {hi_q, mem_rdata};
                flush_de = 1'b1;
                state_d  = StIdle;
            end
            // Low half is pushed first so the RET pop (high then low) sees it last.
            StIntPushHi: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_wdata = epc_q[HALF_W-1:0];
                sp_dec    = 1'b1;
                state_d   = StIntPushLo;
            end
            StIntPushLo: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_wdata = epc_q[PC_W-1:HALF_W];
                sp_dec    = 1'b1;
                state_d   = StIntLd;
            end
            StIntLd: begin
                pc_load  = 1'b1;
                pc_next  = INT_VECTOR;
                flush_de = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase

        busy      = (state_q != StIdle);
        freeze_pc = busy;
        flush_fd  = flush_fd | busy;

        if (stall) begin
            state_d = state_q;
            hi_d    = hi_q;
            epc_d   = epc_q;
            mem_req = 1'b0;
            sp_inc  = 1'b0;
            sp_dec  = 1'b0;
            pc_load = 1'b0;
        end
    end

`ifdef REDIRECT_STAT_EN
    redirect_stat_cnt u_stat_cnt (
        .clk (clk),
        .rst (rst),
        .inc (pc_load),
        .cnt (redirect_cnt)
    );
`endif

endmodule
